// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM states
// and the strobe priority encoder.
package hilo_muldiv_unit_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MADD  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Only one strobe is ever legal at a time; the fixed order just makes
  // illegal combinations deterministic.
  function automatic md_op_e md_prio(input logic mult, input logic multu,
                                     input logic div, input logic divu,
                                     input logic madd, input logic mthi,
                                     input logic mtlo);
    if (mult)       return MD_MULT;
    else if (multu) return MD_MULTU;
    else if (div)   return MD_DIV;
    else if (divu)  return MD_DIVU;
    else if (madd)  return MD_MADD;
    else if (mthi)  return MD_MTHI;
    else if (mtlo)  return MD_MTLO;
    else            return MD_NONE;
  endfunction

  function automatic logic md_is_arith(input md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD};
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage operand/strobe bundle into the mul/div unit and HI/LO/Busy back out.
interface hilo_muldiv_unit_if;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        madd;
  logic        mthi;
  logic        mtlo;
  logic        Busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output Data1, Data2, mult, multu, div, divu, madd, mthi, mtlo,
    input  Busy, hi, lo
  );

  modport slave (
    input  Data1, Data2, mult, multu, div, divu, madd, mthi, mtlo,
    output Busy, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit_md_div_core.sv
// Combinational 32-bit signed/unsigned divider: truncating quotient, remainder
// carrying the dividend's sign, and a divide-by-zero flag.
module md_div_core (
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_signed,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_div0
);

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_a_neg = i_signed & i_dividend[31];
  assign w_b_neg = i_signed & i_divisor[31];
  assign o_div0  = (i_divisor == 32'd0);

  // Magnitudes stay 32-bit unsigned, so 0x80000000 / -1 wraps to 0x80000000.
  assign w_a_mag = w_a_neg ? (~i_dividend + 32'd1) : i_dividend;
  assign w_b_mag = w_b_neg ? (~i_divisor + 32'd1)  : i_divisor;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_q_mag = 32'd0;
    w_r_mag = 32'd0;
    if (!o_div0) begin
      w_q_mag = w_a_mag / w_b_mag;
      w_r_mag = w_a_mag % w_b_mag;
    end
  end

  assign o_quot = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign o_rem  = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Arithmetic ops compute at issue,
// hold the result pending for a fixed number of Busy cycles, then commit to HI/LO.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  hilo_muldiv_unit_if.slave   md_bus
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_issue;
  logic             w_commit;
  md_op_e           w_op;

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_phi;
  logic [31:0]      r_plo;
  logic             r_wr_en;

  logic [63:0]      w_sprod;
  logic [63:0]      w_uprod;
  logic [63:0]      w_result;
  logic             w_wr_en;
  logic [31:0]      w_quot;
  logic [31:0]      w_rem;
  logic             w_div0;

  assign w_op = md_prio(md_bus.mult, md_bus.multu, md_bus.div, md_bus.divu,
                        md_bus.madd, md_bus.mthi, md_bus.mtlo);

  // Explicit 64-bit extension keeps the product full width without relying on context sizing.
  assign w_sprod = {{32{md_bus.Data1[31]}}, md_bus.Data1} * {{32{md_bus.Data2[31]}}, md_bus.Data2};
  assign w_uprod = {32'd0, md_bus.Data1} * {32'd0, md_bus.Data2};

  md_div_core u_div (
    .i_dividend (md_bus.Data1),
    .i_divisor  (md_bus.Data2),
    .i_signed   (w_op == MD_DIV),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div0     (w_div0)
  );

  always_comb begin
    w_result = 64'd0;
    w_wr_en  = 1'b1;
    case (w_op)
      MD_MULT:  w_result = w_sprod;
      MD_MULTU: w_result = w_uprod;
      MD_MADD:  w_result = {r_hi, r_lo} + w_sprod;
      MD_DIV, MD_DIVU: begin
        w_result = {w_rem, w_quot};
        w_wr_en  = ~w_div0;  // divide by zero still runs, but leaves HI/LO alone
      end
      default:  w_result = 64'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md_is_arith(w_op)) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = md_is_div(w_op) ? DIV_N : MULT_N;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: the pending result is reset too, so an aborted operation can never leak into HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_wr_en <= 1'b0;
    end else if (w_issue) begin
      r_phi   <= w_result[63:32];
      r_plo   <= w_result[31:0];
      r_wr_en <= w_wr_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (r_wr_en) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (r_state == ST_IDLE) begin
      if (w_op == MD_MTHI) r_hi <= md_bus.Data1;
      if (w_op == MD_MTLO) r_lo <= md_bus.Data1;
    end
  end

  assign md_bus.Busy = (r_state == ST_RUN);
  assign md_bus.hi   = r_hi;
  assign md_bus.lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: Busy length, HI/LO results, mthi/mtlo,
// divide-by-zero, signed overflow divide, madd carry and reset abort.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit_if md_bus ();

  hilo_muldiv_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .md_bus (md_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    md_bus.Data1 = a;
    md_bus.Data2 = b;
    md_bus.mult  = (op == MD_MULT);
    md_bus.multu = (op == MD_MULTU);
    md_bus.div   = (op == MD_DIV);
    md_bus.divu  = (op == MD_DIVU);
    md_bus.madd  = (op == MD_MADD);
    md_bus.mthi  = (op == MD_MTHI);
    md_bus.mtlo  = (op == MD_MTLO);
  endtask

  // One-cycle strobe; counts Busy cycles (bounded) and checks HI/LO on the first idle cycle.
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    cyc = 0;
    @(negedge clk);
    drive(op, a, b);
    @(posedge clk);
    #1 drive(MD_NONE, 32'd0, 32'd0);
    while (cyc < 40) begin
      @(negedge clk);
      if (!md_bus.Busy) break;
      cyc++;
    end
    check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " hi"}, md_bus.hi, exp_hi);
    check({tag, " lo"}, md_bus.lo, exp_lo);
  endtask

  task automatic move_to(input string tag, input md_op_e op, input logic [31:0] val);
    @(negedge clk);
    drive(op, val, 32'd0);
    @(posedge clk);
    #1 drive(MD_NONE, 32'd0, 32'd0);
    check({tag, " busy"}, {31'd0, md_bus.Busy}, 32'd0);
    if (op == MD_MTHI) check({tag, " hi"}, md_bus.hi, val);
    else               check({tag, " lo"}, md_bus.lo, val);
  endtask

  initial begin
    reset = 1'b1;
    drive(MD_NONE, 32'd0, 32'd0);
    #12;
    check("reset busy", {31'd0, md_bus.Busy}, 32'd0);
    check("reset hi", md_bus.hi, 32'd0);
    check("reset lo", md_bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // -3 * 7 = -21
    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    // -7 / 2 = -3 rem -1
    run_op("div neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // 7 / -2 = -3 rem 1
    run_op("div negdivisor", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    // 0xFFFFFFF9 unsigned / 2 = 0x7FFFFFFC rem 1
    run_op("divu big", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    move_to("mthi 5", MD_MTHI, 32'd5);
    move_to("mtlo 6", MD_MTLO, 32'd6);
    check("mtlo keeps hi", md_bus.hi, 32'd5);
    run_op("div by zero", MD_DIV, 32'd9, 32'd0, 10, 32'd5, 32'd6);
    run_op("divu by zero", MD_DIVU, 32'd9, 32'd0, 10, 32'd5, 32'd6);

    // {0, 10} + 3*4 = 22
    move_to("mtlo 10", MD_MTLO, 32'd10);
    move_to("mthi 0", MD_MTHI, 32'd0);
    run_op("madd 3x4", MD_MADD, 32'd3, 32'd4, 5, 32'd0, 32'd22);
    // {0, FFFFFFFF} + 1 carries into hi
    move_to("mtlo ones", MD_MTLO, 32'hFFFF_FFFF);
    move_to("mthi 0b", MD_MTHI, 32'd0);
    run_op("madd carry", MD_MADD, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    // {1, 0} + (-1 * 1) = {0, FFFFFFFF}
    run_op("madd neg", MD_MADD, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);

    // Reset during busy cycle 4 of a divide
    @(negedge clk);
    drive(MD_DIVU, 32'd100, 32'd3);
    @(posedge clk);
    #1 drive(MD_NONE, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", {31'd0, md_bus.Busy}, 32'd0);
    check("abort hi", md_bus.hi, 32'd0);
    check("abort lo", md_bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort no late commit hi", md_bus.hi, 32'd0);
    check("abort no late commit lo", md_bus.lo, 32'd0);
    check("abort stays idle", {31'd0, md_bus.Busy}, 32'd0);
    run_op("mult after reset", MD_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
